// File: rtl/if_id_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS CPU.
// Owns the PC and the next-PC priority chain: branch, stall, illegal-op trap,
// JR, J, interrupt entry and sequential fetch. PC[31] marks kernel mode.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP    = 32'h8000_0004,
  parameter logic [31:0] XADR     = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IM_Instruct,
  input  logic        IRQ,
  input  logic        ID_Stall,
  input  logic        EX_Branch_EN,
  input  logic [31:0] EX_ConBA,
  input  logic        ID_Jump_EN,
  input  logic [25:0] ID_JT,
  input  logic        ID_JR_EN,
  input  logic [31:0] ID_JR_Addr,
  input  logic        ID_Exception,
  output logic [31:0] IF_PC,
  output logic [31:0] ID_Instruct,
  output logic [31:0] ID_PC,
  output logic        ID_IRQ,
  output logic        ID_Valid
);

  // Which source feeds the PC this cycle; also decides the IF/ID update.
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_STALL,
    SEL_EXCEPT,
    SEL_JR,
    SEL_JUMP,
    SEL_IRQ
  } sel_e;

  logic [31:0] r_pc;
  logic [31:0] r_idInstruct;
  logic [31:0] r_idPc;
  logic        r_idIrq;
  logic        r_idValid;

  sel_e        w_sel;
  logic [31:0] w_nextPc;
  logic [31:0] w_seqPc;
  logic [31:0] w_jumpTarget;

  // The supervisor bit is carried through untouched; only bits 30:0 increment.
  assign w_seqPc      = {r_pc[31], r_pc[30:0] + 31'd4};
  assign w_jumpTarget = {r_idPc[31:28], ID_JT, 2'b00};

  // Priority chain for the next fetch address; a taken branch beats everything
  // because the ID instruction behind it is wrong-path.
  always_comb begin
    w_sel    = SEL_SEQ;
    w_nextPc = w_seqPc;
    if (EX_Branch_EN) begin
      w_sel    = SEL_BRANCH;
      w_nextPc = EX_ConBA;
    end else if (ID_Stall) begin
      w_sel    = SEL_STALL;
      w_nextPc = r_pc;
    end else if (ID_Exception) begin
      w_sel    = SEL_EXCEPT;
      w_nextPc = ILLOP;
    end else if (ID_JR_EN) begin
      w_sel    = SEL_JR;
      w_nextPc = ID_JR_Addr;
    end else if (ID_Jump_EN) begin
      w_sel    = SEL_JUMP;
      w_nextPc = w_jumpTarget;
    end else if (IRQ && !r_pc[31]) begin
      w_sel    = SEL_IRQ;
      w_nextPc = XADR;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_nextPc;
    end
  end

  // IF/ID register: flush on redirect, hold on stall, bubble carrying the
  // resume PC on interrupt entry, otherwise capture the fetched instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idInstruct <= 32'd0;
      r_idPc       <= 32'd0;
      r_idIrq      <= 1'b0;
      r_idValid    <= 1'b0;
    end else begin
      case (w_sel)
        SEL_STALL: begin
          r_idInstruct <= r_idInstruct;
          r_idPc       <= r_idPc;
          r_idIrq      <= r_idIrq;
          r_idValid    <= r_idValid;
        end
        SEL_IRQ: begin
          r_idInstruct <= 32'd0;
          r_idPc       <= r_pc;
          r_idIrq      <= 1'b1;
          r_idValid    <= 1'b0;
        end
        SEL_SEQ: begin
          r_idInstruct <= IM_Instruct;
          r_idPc       <= w_seqPc;
          r_idIrq      <= 1'b0;
          r_idValid    <= 1'b1;
        end
        default: begin
          r_idInstruct <= 32'd0;
          r_idPc       <= 32'd0;
          r_idIrq      <= 1'b0;
          r_idValid    <= 1'b0;
        end
      endcase
    end
  end

  assign IF_PC       = r_pc;
  assign ID_Instruct = r_idInstruct;
  assign ID_PC       = r_idPc;
  assign ID_IRQ      = r_idIrq;
  assign ID_Valid    = r_idValid;

endmodule
